// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Decode-stage register scoreboard and issue interlock for the segre
//   in-order pipeline. It tracks every in-flight register write and counts
//   down the cycles until that result reaches a bypass point. It holds the
//   ID instruction while a source cannot be forwarded yet, or while a
//   destination still has an unknown-latency write outstanding. Hazard
//   stall cycles are counted for performance analysis.
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   id_valid_i                valid instruction in ID
//   id_rs1_i/id_rs2_i         source indices; id_rs*_used_i marks a real read
//   id_rd_i, id_rd_we_i       destination index and write enable
//   id_lat_i                  cycles after issue until bypassable (all-ones = unknown)
//   ex_stall_i                back-end freeze: counters hold, nothing issues
//   flush_i                   ID instruction squashed this cycle
//   wb_valid_i, wb_rd_i       register write retiring at WB
//   kill_valid_i, kill_rd_i   squashed unknown-latency producer
//   id_stall_o                hold ID (combinational from state and inputs)
//   busy_o                    per-register busy bits (registered)
//   stall_cnt_o               hazard stall cycle counter (registered, wraps)
module hazard_scoreboard #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned LAT_W    = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                id_valid_i,
  input  logic [4:0]          id_rs1_i,
  input  logic [4:0]          id_rs2_i,
  input  logic                id_rs1_used_i,
  input  logic                id_rs2_used_i,
  input  logic [4:0]          id_rd_i,
  input  logic                id_rd_we_i,
  input  logic [LAT_W-1:0]    id_lat_i,
  input  logic                ex_stall_i,
  input  logic                flush_i,
  input  logic                wb_valid_i,
  input  logic [4:0]          wb_rd_i,
  input  logic                kill_valid_i,
  input  logic [4:0]          kill_rd_i,
  output logic                id_stall_o,
  output logic [NUM_REGS-1:0] busy_o,
  output logic [31:0]         stall_cnt_o
);

  localparam int unsigned IDX_W   = 5;
  localparam int unsigned CNT_W   = 32;
  localparam logic [LAT_W-1:0] LAT_UNKNOWN = '1;

  // Scoreboard state
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [LAT_W-1:0]    cnt_q [NUM_REGS];
  logic [LAT_W-1:0]    cnt_d [NUM_REGS];
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic rs1_not_ready;
  logic rs2_not_ready;
  logic raw_hazard;
  logic waw_hazard;
  logic issue;
  logic count_stall;

  // Operand readiness: x0 and idle entries are always ready, and a busy
  // entry becomes forwardable once its countdown reaches zero.
  always_comb begin
    rs1_not_ready = id_rs1_used_i && (id_rs1_i != '0) &&
                    busy_q[id_rs1_i] && (cnt_q[id_rs1_i] != '0);
    rs2_not_ready = id_rs2_used_i && (id_rs2_i != '0) &&
                    busy_q[id_rs2_i] && (cnt_q[id_rs2_i] != '0);
  end

  // Hazard detection and issue decision
  always_comb begin
    raw_hazard  = id_valid_i && (rs1_not_ready || rs2_not_ready);
    // A second write must not overtake an outstanding unknown-latency one,
    // otherwise its WB could clear the newer entry.
    waw_hazard  = id_valid_i && id_rd_we_i && (id_rd_i != '0) &&
                  busy_q[id_rd_i] && (cnt_q[id_rd_i] == LAT_UNKNOWN);
    id_stall_o  = raw_hazard || waw_hazard || ex_stall_i;
    issue       = id_valid_i && !id_stall_o && !flush_i;
    count_stall = (raw_hazard || waw_hazard) && !ex_stall_i && !flush_i;
  end

  // Next-state for every entry; later assignments take priority:
  // countdown < retire/kill clear < new issue.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      if (!ex_stall_i && busy_q[r] && (cnt_q[r] != '0) &&
          (cnt_q[r] != LAT_UNKNOWN)) begin
        cnt_d[r] = cnt_q[r] - LAT_W'(1);
      end
      if ((wb_valid_i && (wb_rd_i == IDX_W'(r))) ||
          (kill_valid_i && (kill_rd_i == IDX_W'(r)))) begin
        busy_d[r] = 1'b0;
        cnt_d[r]  = '0;
      end
      if (issue && id_rd_we_i && (id_rd_i == IDX_W'(r))) begin
        busy_d[r] = 1'b1;
        cnt_d[r]  = id_lat_i;
      end
    end
    // x0 is never recorded
    busy_d[0] = 1'b0;
    cnt_d[0]  = '0;
  end

  // Hazard stall counter, wraps at 2^32
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (count_stall) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q      <= '0;
      cnt_q       <= '{default: '0};
      stall_cnt_q <= '0;
    end else begin
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign busy_o      = busy_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
//   Directed bench for hazard_scoreboard: one task per scenario, each with
//   hand-computed expectations for id_stall_o, busy_o and stall_cnt_o.
module tb_hazard_scoreboard;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_valid_i;
  logic [4:0]  id_rs1_i, id_rs2_i;
  logic        id_rs1_used_i, id_rs2_used_i;
  logic [4:0]  id_rd_i;
  logic        id_rd_we_i;
  logic [2:0]  id_lat_i;
  logic        ex_stall_i;
  logic        flush_i;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;
  logic        kill_valid_i;
  logic [4:0]  kill_rd_i;
  logic        id_stall_o;
  logic [31:0] busy_o;
  logic [31:0] stall_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_scoreboard #(.NUM_REGS(32), .LAT_W(3)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .id_valid_i    (id_valid_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_rs1_used_i (id_rs1_used_i),
    .id_rs2_used_i (id_rs2_used_i),
    .id_rd_i       (id_rd_i),
    .id_rd_we_i    (id_rd_we_i),
    .id_lat_i      (id_lat_i),
    .ex_stall_i    (ex_stall_i),
    .flush_i       (flush_i),
    .wb_valid_i    (wb_valid_i),
    .wb_rd_i       (wb_rd_i),
    .kill_valid_i  (kill_valid_i),
    .kill_rd_i     (kill_rd_i),
    .id_stall_o    (id_stall_o),
    .busy_o        (busy_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock; return 1 time unit after the edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    id_valid_i    = 1'b0;
    id_rs1_i      = '0;
    id_rs2_i      = '0;
    id_rs1_used_i = 1'b0;
    id_rs2_used_i = 1'b0;
    id_rd_i       = '0;
    id_rd_we_i    = 1'b0;
    id_lat_i      = '0;
    ex_stall_i    = 1'b0;
    flush_i       = 1'b0;
    wb_valid_i    = 1'b0;
    wb_rd_i       = '0;
    kill_valid_i  = 1'b0;
    kill_rd_i     = '0;
  endtask

  // Present one ID instruction (other inputs left as they are)
  task automatic set_id(input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic we,
                        input logic [2:0] lat);
    id_valid_i    = 1'b1;
    id_rs1_i      = rs1;
    id_rs1_used_i = u1;
    id_rs2_i      = rs2;
    id_rs2_used_i = u2;
    id_rd_i       = rd;
    id_rd_we_i    = we;
    id_lat_i      = lat;
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (busy_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_busy got %h want %h", busy_o, 32'h0);
    end
    n_checks++;
    if (stall_cnt_o !== 32'd0) begin
      n_fail++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt_o);
    end
    set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 3'd0);
    #1;
    n_checks++;
    if (id_stall_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_id_stall got %b want 0", id_stall_o);
    end
    idle();
    tick();
  endtask

  task automatic test_alu_forward();
    do_reset();
    set_id(5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 3'd0);
    #1;
    n_checks++;
    if (id_stall_o !== 1'b0) begin
      n_fail++; $display("FAIL alu_issue_stall got %b want 0", id_stall_o);
    end
    tick();
    set_id(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 3'd0);
    #1;
    n_checks++;
    if (id_stall_o !== 1'b0) begin
      n_fail++; $display("FAIL alu_dep_stall got %b want 0", id_stall_o);
    end
    n_checks++;
    if (busy_o[5] !== 1'b1) begin
      n_fail++; $display("FAIL alu_busy5_after_issue got %b want 1", busy_o[5]);
    end
    tick();
    idle();
    wb_valid_i = 1'b1;
    wb_rd_i    = 5'd5;
    #1;
    n_checks++;
    if (busy_o[6:5] !== 2'b11) begin
      n_fail++; $display("FAIL alu_busy_pre_wb got %b want 11", busy_o[6:5]);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (busy_o[6:5] !== 2'b10) begin
      n_fail++; $display("FAIL alu_busy_post_wb got %b want 10", busy_o[6:5]);
    end
    n_checks++;
    if (stall_cnt_o !== 32'd0) begin
      n_fail++; $display("FAIL alu_stall_cnt got %0d want 0", stall_cnt_o);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 3'd1);
    tick();
    set_id(5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 3'd0);
    #1;
    n_checks++;
    if (id_stall_o !== 1'b1) begin
      n_fail++; $display("FAIL load_use_bubble got %b want 1", id_stall_o);
    end
    tick();
    #1;
    n_checks++;
    if (id_stall_o !== 1'b0) begin
      n_fail++; $display("FAIL load_use_issue got %b want 0", id_stall_o);
    end
    tick();
    idle();
    n_checks++;
    if (stall_cnt_o !== 32'd1) begin
      n_fail++; $display("FAIL load_use_stall_cnt got %0d want 1", stall_cnt_o);
    end
    n_checks++;
    if (busy_o[8] !== 1'b1) begin
      n_fail++; $display("FAIL load_use_busy8 got %b want 1", busy_o[8]);
    end
  endtask

  task automatic test_unknown_latency();
    do_reset();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 3'd7);
    tick();
    for (int i = 1; i <= 10; i++) begin
      idle();
      set_id(5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 3'd0);
      if (i == 10) begin
        wb_valid_i = 1'b1;
        wb_rd_i    = 5'd9;
      end
      #1;
      n_checks++;
      if (id_stall_o !== 1'b1) begin
        n_fail++; $display("FAIL div_wait_cycle%0d got %b want 1", i, id_stall_o);
      end
      tick();
    end
    idle();
    set_id(5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 3'd0);
    #1;
    n_checks++;
    if (id_stall_o !== 1'b0) begin
      n_fail++; $display("FAIL div_dep_issue got %b want 0", id_stall_o);
    end
    tick();
    idle();
    n_checks++;
    if (stall_cnt_o !== 32'd10) begin
      n_fail++; $display("FAIL div_stall_cnt got %0d want 10", stall_cnt_o);
    end
    n_checks++;
    if (busy_o[10:9] !== 2'b10) begin
      n_fail++; $display("FAIL div_busy got %b want 10", busy_o[10:9]);
    end
  endtask

  task automatic test_waw();
    do_reset();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 3'd7);
    tick();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 3'd0);
    #1;
    n_checks++;
    if (id_stall_o !== 1'b1) begin
      n_fail++; $display("FAIL waw_stall got %b want 1", id_stall_o);
    end
    tick();
    wb_valid_i = 1'b1;
    wb_rd_i    = 5'd9;
    #1;
    n_checks++;
    if (id_stall_o !== 1'b1) begin
      n_fail++; $display("FAIL waw_stall_wb_cycle got %b want 1", id_stall_o);
    end
    tick();
    wb_valid_i = 1'b0;
    #1;
    n_checks++;
    if (id_stall_o !== 1'b0) begin
      n_fail++; $display("FAIL waw_issue got %b want 0", id_stall_o);
    end
    tick();
    // Known-latency destination rewritten immediately: no WAW stall
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 3'd2);
    tick();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 3'd2);
    #1;
    n_checks++;
    if (id_stall_o !== 1'b0) begin
      n_fail++; $display("FAIL waw_known_lat got %b want 0", id_stall_o);
    end
    tick();
    idle();
    n_checks++;
    if (stall_cnt_o !== 32'd2) begin
      n_fail++; $display("FAIL waw_stall_cnt got %0d want 2", stall_cnt_o);
    end
    n_checks++;
    if (busy_o[11] !== 1'b1 || busy_o[9] !== 1'b1) begin
      n_fail++; $display("FAIL waw_busy got %b want 11", {busy_o[11], busy_o[9]});
    end
  endtask

  task automatic test_ex_stall();
    do_reset();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 3'd2);
    tick();
    set_id(5'd3, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 3'd0);
    for (int i = 0; i < 5; i++) begin
      ex_stall_i = (i < 3);
      #1;
      n_checks++;
      if (id_stall_o !== 1'b1) begin
        n_fail++; $display("FAIL exstall_hold_cycle%0d got %b want 1", i, id_stall_o);
      end
      tick();
    end
    ex_stall_i = 1'b0;
    #1;
    n_checks++;
    if (id_stall_o !== 1'b0) begin
      n_fail++; $display("FAIL exstall_issue got %b want 0", id_stall_o);
    end
    tick();
    idle();
    n_checks++;
    if (stall_cnt_o !== 32'd2) begin
      n_fail++; $display("FAIL exstall_stall_cnt got %0d want 2", stall_cnt_o);
    end
  endtask

  task automatic test_flush();
    do_reset();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 3'd1);
    tick();
    // Hazard while flushed: stalls but is not counted
    set_id(5'd13, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
    flush_i = 1'b1;
    #1;
    n_checks++;
    if (id_stall_o !== 1'b1) begin
      n_fail++; $display("FAIL flush_hazard_stall got %b want 1", id_stall_o);
    end
    tick();
    // Flushed issuable write must not be recorded
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd14, 1'b1, 3'd7);
    flush_i = 1'b1;
    tick();
    idle();
    n_checks++;
    if (busy_o[14] !== 1'b0) begin
      n_fail++; $display("FAIL flush_no_record got %b want 0", busy_o[14]);
    end
    n_checks++;
    if (stall_cnt_o !== 32'd0) begin
      n_fail++; $display("FAIL flush_stall_cnt got %0d want 0", stall_cnt_o);
    end
  endtask

  task automatic test_kill();
    do_reset();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 3'd7);
    tick();
    set_id(5'd4, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 3'd0);
    kill_valid_i = 1'b1;
    kill_rd_i    = 5'd4;
    wb_valid_i   = 1'b1;
    wb_rd_i      = 5'd4;
    #1;
    n_checks++;
    if (id_stall_o !== 1'b1) begin
      n_fail++; $display("FAIL kill_cycle_stall got %b want 1", id_stall_o);
    end
    tick();
    kill_valid_i = 1'b0;
    wb_valid_i   = 1'b0;
    #1;
    n_checks++;
    if (busy_o[4] !== 1'b0) begin
      n_fail++; $display("FAIL kill_busy4 got %b want 0", busy_o[4]);
    end
    n_checks++;
    if (id_stall_o !== 1'b0) begin
      n_fail++; $display("FAIL kill_dep_issue got %b want 0", id_stall_o);
    end
    tick();
    // x4 with L=2, then re-issue x4 L=2 in the same cycle as its WB
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 3'd2);
    tick();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 3'd2);
    wb_valid_i = 1'b1;
    wb_rd_i    = 5'd4;
    tick();
    idle();
    n_checks++;
    if (busy_o[4] !== 1'b1) begin
      n_fail++; $display("FAIL issue_over_wb_busy got %b want 1", busy_o[4]);
    end
    set_id(5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (id_stall_o !== 1'b1) begin
        n_fail++; $display("FAIL issue_over_wb_cnt%0d got %b want 1", i, id_stall_o);
      end
      tick();
    end
    #1;
    n_checks++;
    if (id_stall_o !== 1'b0) begin
      n_fail++; $display("FAIL issue_over_wb_ready got %b want 0", id_stall_o);
    end
    tick();
    idle();
  endtask

  task automatic test_x0();
    do_reset();
    set_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 3'd7);
    #1;
    n_checks++;
    if (id_stall_o !== 1'b0) begin
      n_fail++; $display("FAIL x0_first_stall got %b want 0", id_stall_o);
    end
    tick();
    #1;
    n_checks++;
    if (id_stall_o !== 1'b0) begin
      n_fail++; $display("FAIL x0_second_stall got %b want 0", id_stall_o);
    end
    n_checks++;
    if (busy_o !== 32'h0) begin
      n_fail++; $display("FAIL x0_busy got %h want %h", busy_o, 32'h0);
    end
    tick();
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b1, 3'd7);
    tick();
    set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd21, 1'b1, 3'd6);
    tick();
    set_id(5'd20, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
    tick();
    idle();
    n_checks++;
    if (busy_o[21:20] !== 2'b11 || stall_cnt_o !== 32'd1) begin
      n_fail++; $display("FAIL midrst_pre got busy %b cnt %0d want 11 1", busy_o[21:20], stall_cnt_o);
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    n_checks++;
    if (busy_o !== 32'h0) begin
      n_fail++; $display("FAIL midrst_busy got %h want %h", busy_o, 32'h0);
    end
    n_checks++;
    if (stall_cnt_o !== 32'd0) begin
      n_fail++; $display("FAIL midrst_stall_cnt got %0d want 0", stall_cnt_o);
    end
    set_id(5'd20, 1'b1, 5'd21, 1'b1, 5'd0, 1'b0, 3'd0);
    #1;
    n_checks++;
    if (id_stall_o !== 1'b0) begin
      n_fail++; $display("FAIL midrst_id_stall got %b want 0", id_stall_o);
    end
    tick();
    idle();
  endtask

  initial begin
    idle();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    test_reset();
    test_alu_forward();
    test_load_use();
    test_unknown_latency();
    test_waw();
    test_ex_stall();
    test_flush();
    test_kill();
    test_x0();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
